// File: rtl/change_dispenser.sv
// Greedy three-denomination change dispenser with valid/ack coin ejector handshake.
// Define STUCK_TIMEOUT_EN to abort a dispense when the ejector stops acking.
module change_dispenser #(
  parameter int AMT_W = 4,
  parameter int D_HI  = 5,
  parameter int D_MID = 2,
  parameter int D_LO  = 1
`ifdef STUCK_TIMEOUT_EN
  ,parameter int TIMEOUT = 15
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill_en,
  input  logic [AMT_W-1:0] refill_hi,
  input  logic [AMT_W-1:0] refill_mid,
  input  logic [AMT_W-1:0] refill_lo,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             redlight,
  output logic [AMT_W-1:0] inv_hi,
  output logic [AMT_W-1:0] inv_mid,
  output logic [AMT_W-1:0] inv_lo,
  output logic [AMT_W-1:0] undispensed
);

  localparam int PW = AMT_W + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_PLAN, S_DISP, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] amt;
  logic [AMT_W-1:0] p_hi, p_mid, p_lo;

  logic [PW-1:0] a_w, q_hi, q_mid, q_lo;
  logic [PW-1:0] t_hi, t_mid, t_lo;
  logic [PW-1:0] r1, r2, r3;

  always_comb begin
    a_w   = PW'(amt);
    q_hi  = a_w / PW'(D_HI);
    t_hi  = (q_hi < PW'(inv_hi)) ? q_hi : PW'(inv_hi);
    r1    = a_w - t_hi * PW'(D_HI);
    q_mid = r1 / PW'(D_MID);
    t_mid = (q_mid < PW'(inv_mid)) ? q_mid : PW'(inv_mid);
    r2    = r1 - t_mid * PW'(D_MID);
    q_lo  = r2 / PW'(D_LO);
    t_lo  = (q_lo < PW'(inv_lo)) ? q_lo : PW'(inv_lo);
    r3    = r2 - t_lo * PW'(D_LO);
  end

  function automatic logic [1:0] pick(
    input logic [AMT_W-1:0] h,
    input logic [AMT_W-1:0] m
  );
    if (h != '0)      return 2'd2;
    else if (m != '0) return 2'd1;
    else              return 2'd0;
  endfunction

  // pending counts as they will be once the presented coin is acked
  logic [AMT_W-1:0] d_hi, d_mid, d_lo;
  logic             nxt_any;

  always_comb begin
    d_hi  = p_hi;
    d_mid = p_mid;
    d_lo  = p_lo;
    case (coin_type)
      2'd2:    d_hi  = p_hi - 1'b1;
      2'd1:    d_mid = p_mid - 1'b1;
      default: d_lo  = p_lo - 1'b1;
    endcase
    nxt_any = (d_hi != '0) || (d_mid != '0) || (d_lo != '0);
  end

`ifdef STUCK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]  cnt;
  logic [PW-1:0]    left_w;
  assign left_w = PW'(p_hi) * PW'(D_HI)
                + PW'(p_mid) * PW'(D_MID)
                + PW'(p_lo) * PW'(D_LO);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      amt         <= '0;
      p_hi        <= '0;
      p_mid       <= '0;
      p_lo        <= '0;
      inv_hi      <= '0;
      inv_mid     <= '0;
      inv_lo      <= '0;
      coin_valid  <= 1'b0;
      coin_type   <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      redlight    <= 1'b0;
      undispensed <= '0;
`ifdef STUCK_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (refill_en) begin
            inv_hi  <= refill_hi;
            inv_mid <= refill_mid;
            inv_lo  <= refill_lo;
          end
          if (start && mode) begin
            amt      <= amount;
            redlight <= 1'b0;
            busy     <= 1'b1;
            state    <= S_PLAN;
          end
        end
        S_PLAN: begin
          p_hi  <= t_hi[AMT_W-1:0];
          p_mid <= t_mid[AMT_W-1:0];
          p_lo  <= t_lo[AMT_W-1:0];
          if (r3 != '0) begin
            redlight    <= 1'b1;
            undispensed <= amt;
            done        <= 1'b1;
            state       <= S_ERR;
          end else if (amt == '0) begin
            undispensed <= '0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            coin_valid <= 1'b1;
            coin_type  <= pick(t_hi[AMT_W-1:0], t_mid[AMT_W-1:0]);
            state      <= S_DISP;
          end
        end
        S_DISP: begin
          if (coin_ack) begin
            p_hi  <= d_hi;
            p_mid <= d_mid;
            p_lo  <= d_lo;
            case (coin_type)
              2'd2:    inv_hi  <= inv_hi - 1'b1;
              2'd1:    inv_mid <= inv_mid - 1'b1;
              default: inv_lo  <= inv_lo - 1'b1;
            endcase
`ifdef STUCK_TIMEOUT_EN
            cnt <= '0;
`endif
            if (nxt_any) begin
              coin_type <= pick(d_hi, d_mid);
            end else begin
              coin_valid  <= 1'b0;
              coin_type   <= 2'd0;
              undispensed <= '0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
`ifdef STUCK_TIMEOUT_EN
          else if (cnt == TO_W'(TIMEOUT - 1)) begin
            cnt         <= '0;
            coin_valid  <= 1'b0;
            coin_type   <= 2'd0;
            redlight    <= 1'b1;
            undispensed <= left_w[AMT_W-1:0];
            done        <= 1'b1;
            state       <= S_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random traffic
// checked every cycle against a transaction-level coin-queue model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amount = '0;
  logic       refill_en = 1'b0;
  logic [3:0] refill_hi = '0, refill_mid = '0, refill_lo = '0;
  logic       coin_ack = 1'b0;
  logic       coin_valid, busy, done, redlight;
  logic [1:0] coin_type;
  logic [3:0] inv_hi, inv_mid, inv_lo, undispensed;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start),
    .amount(amount), .refill_en(refill_en),
    .refill_hi(refill_hi), .refill_mid(refill_mid),
    .refill_lo(refill_lo), .coin_valid(coin_valid),
    .coin_type(coin_type), .coin_ack(coin_ack), .busy(busy),
    .done(done), .redlight(redlight), .inv_hi(inv_hi),
    .inv_mid(inv_mid), .inv_lo(inv_lo),
    .undispensed(undispensed)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // model: coin values indexed 0=lo 1=mid 2=hi
  int  den [3] = '{1, 2, 5};
  bit  armed = 1'b0;
  bit  m_busy, m_valid, m_done, m_red, m_plan, m_fin;
  int  m_type, m_und, m_amt;
  int  m_inv [3];
  int  q [$];

  task automatic model_step();
    int rem;
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_red = 0;
      m_plan = 0; m_fin = 0; m_type = 0; m_und = 0;
      m_amt = 0;
      m_inv = '{0, 0, 0};
      q.delete();
      armed = 1'b1;
      return;
    end
    if (!armed) return;
    m_done = 0;
    if (m_fin) begin
      m_fin = 0;
      m_busy = 0;
    end else if (m_plan) begin
      m_plan = 0;
      rem = m_amt;
      q.delete();
      for (int k = 2; k >= 0; k--) begin
        int n = 0;
        while (rem >= den[k] && n < m_inv[k]) begin
          rem -= den[k];
          n++;
          q.push_back(k);
        end
      end
      if (rem != 0) begin
        m_red = 1; m_und = m_amt; m_done = 1; m_fin = 1;
      end else if (q.size() == 0) begin
        m_und = 0; m_done = 1; m_fin = 1;
      end else begin
        m_valid = 1; m_type = q[0];
      end
    end else if (m_valid) begin
      if (coin_ack) begin
        m_inv[q[0]]--;
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_valid = 0; m_done = 1; m_und = 0; m_fin = 1;
        end else begin
          m_type = q[0];
        end
      end
    end else if (!m_busy) begin
      if (refill_en) begin
        m_inv[2] = refill_hi;
        m_inv[1] = refill_mid;
        m_inv[0] = refill_lo;
      end
      if (start && mode) begin
        m_amt = amount; m_red = 0; m_busy = 1; m_plan = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, m_busy);
      check("coin_valid", coin_valid, m_valid);
      check("done", done, m_done);
      check("redlight", redlight, m_red);
      check("undispensed", undispensed, m_und);
      check("inv_hi", inv_hi, m_inv[2]);
      check("inv_mid", inv_mid, m_inv[1]);
      check("inv_lo", inv_lo, m_inv[0]);
      if (m_valid) check("coin_type", coin_type, m_type);
    end
    model_step();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int h, input int m, input int l);
    refill_en = 1'b1;
    refill_hi = 4'(h);
    refill_mid = 4'(m);
    refill_lo = 4'(l);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc();
    cyc();
    check("rst_valid", coin_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_inv_hi", inv_hi, 0);
    check("rst_und", undispensed, 0);
    rst_n = 1'b1;

    // T1: 3/3/3, amt 8 -> hi, mid, lo back to back
    refill(3, 3, 3);
    cyc();
    refill_en = 1'b0;
    mode = 1'b1; start = 1'b1; amount = 4'd8; coin_ack = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("t1_valid0", coin_valid, 1);
    check("t1_type0", coin_type, 2);
    cyc();
    check("t1_type1", coin_type, 1);
    cyc();
    check("t1_type2", coin_type, 0);
    cyc();
    check("t1_done", done, 1);
    check("t1_inv_hi", inv_hi, 2);
    check("t1_inv_mid", inv_mid, 2);
    check("t1_inv_lo", inv_lo, 2);
    check("t1_red", redlight, 0);
    cyc();
    check("t1_idle", busy, 0);

    // T2: zero amount
    start = 1'b1; amount = 4'd0;
    cyc();
    start = 1'b0;
    cyc();
    check("t2_done", done, 1);
    check("t2_valid", coin_valid, 0);
    check("t2_und", undispensed, 0);
    cyc();

    // T3: greedy failure with refill in the start cycle
    refill(0, 1, 0);
    start = 1'b1; amount = 4'd3;
    cyc();
    refill_en = 1'b0; start = 1'b0;
    cyc();
    check("t3_red", redlight, 1);
    check("t3_und", undispensed, 3);
    check("t3_done", done, 1);
    cyc();
    check("t3_red_hold", redlight, 1);
    check("t3_inv_mid", inv_mid, 1);

    // T4: stalled ack keeps coin stable
    refill(2, 0, 0);
    start = 1'b1; amount = 4'd10; coin_ack = 1'b0;
    cyc();
    refill_en = 1'b0; start = 1'b0;
    cyc();
    repeat (5) begin
      check("t4_wait_valid", coin_valid, 1);
      check("t4_wait_type", coin_type, 2);
      cyc();
    end
    coin_ack = 1'b1;
    cyc();
    check("t4_second", coin_valid, 1);
    check("t4_inv_hi1", inv_hi, 1);
    cyc();
    check("t4_done", done, 1);
    check("t4_inv_hi0", inv_hi, 0);
    cyc();

    // T5: reset mid-dispense, start while busy ignored
    refill(3, 3, 3);
    start = 1'b1; amount = 4'd8; coin_ack = 1'b0;
    cyc();
    refill_en = 1'b0; start = 1'b0;
    cyc();
    start = 1'b1; amount = 4'd1;
    cyc();
    check("t5_busy_type", coin_type, 2);
    check("t5_busy", busy, 1);
    start = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("t5_valid", coin_valid, 0);
    check("t5_busy0", busy, 0);
    check("t5_inv_hi", inv_hi, 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      mode = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 3) == 0);
      amount = 4'($urandom_range(0, 15));
      refill_en = ($urandom_range(0, 7) == 0);
      refill_hi = 4'($urandom_range(0, 7));
      refill_mid = 4'($urandom_range(0, 7));
      refill_lo = 4'($urandom_range(0, 7));
      coin_ack = ($urandom_range(0, 9) < 6);
      cyc();
    end
    rst_n = 1'b1; start = 1'b0; coin_ack = 1'b1;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
